// File: rtl/mem_sched.sv
// Single-port memory scheduler: shares one synchronous RAM port between
// instruction fetch and data load/store, with alternating arbitration and a watchdog.
module mem_sched #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  // The last-grant bit also identifies the owner of the access being completed.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state, state_n;
  logic              last, last_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              mem_req_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              if_ack_n, d_ack_n;
  logic [DATA_W-1:0] if_rdata_n, d_rdata_n;
  logic              bus_err_n;
  logic              timeout_hit;

  assign timeout_hit = WD_EN && (cnt == CNT_W'(TIMEOUT));
  assign stall       = (if_req & ~if_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= GRANT_I;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      cnt       <= cnt_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_ack    <= if_ack_n;
      d_ack     <= d_ack_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
      bus_err   <= bus_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    last_n      = last;
    cnt_n       = cnt;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_ack_n    = 1'b0;
    d_ack_n     = 1'b0;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    bus_err_n   = bus_err;

    case (state)
      IDLE: begin
        // The counter starts at 1 so it equals the number of cycles spent waiting.
        if (d_req && (!if_req || last == GRANT_I)) begin
          state_n     = DATA;
          last_n      = GRANT_D;
          cnt_n       = CNT_W'(1);
          mem_req_n   = 1'b1;
          mem_we_n    = d_we;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
        end else if (if_req) begin
          state_n    = FETCH;
          last_n     = GRANT_I;
          cnt_n      = CNT_W'(1);
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b0;
          mem_addr_n = if_addr;
        end
      end

      FETCH, DATA: begin
        // An acknowledge on the final watchdog cycle still counts as a normal completion.
        if (mem_ack || timeout_hit) begin
          state_n   = DONE;
          cnt_n     = '0;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          bus_err_n = bus_err | ~mem_ack;
          if (state == FETCH) begin
            if_ack_n   = 1'b1;
            if_rdata_n = mem_ack ? mem_rdata : '0;
          end else begin
            d_ack_n   = 1'b1;
            d_rdata_n = mem_ack ? mem_rdata : '0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_sched.sv
// Scoreboard bench for mem_sched: requester drivers push expected responses,
// a monitor pops them on each ack pulse and audits every memory grant.
module tb_mem_sched;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_ack, d_req, d_we, d_ack;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, stall, bus_err;

  always #5 clk = ~clk;

  mem_sched #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } req_t;

  req_t        fq[$];
  req_t        dq[$];
  logic [31:0] ram     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int lat_cfg  = 1;
  bit rand_lat = 1'b1;
  bit mem_auto = 1'b1;
  int grants   = 0;
  bit first_is_d = 1'b0;
  int last_len = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, record the expected response, hold until ack (bounded).
  task automatic applyStimulus(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit exp_to, output int cycles);
    req_t e;
    bit   got;
    e.addr  = addr;
    e.we    = is_d ? we : 1'b0;
    e.wdata = wdata;
    if (exp_to) e.rdata = 32'h0;
    else begin
      e.rdata = ref_read(addr);
      if (is_d && we) ref_mem[addr] = wdata;
    end
    if (is_d) begin
      dq.push_back(e);
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      fq.push_back(e);
      if_req = 1'b1; if_addr = addr;
    end
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      got = is_d ? d_ack : if_ack;
    end
    checkOutput(is_d ? "d_ack_seen" : "if_ack_seen", {31'b0, got}, 32'h1);
    if (is_d) begin
      d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
    end else begin
      if_req = 1'b0; if_addr = $urandom;
    end
  endtask

  // Behavioural RAM: acknowledges on the lat-th cycle of an access, 0 = never.
  initial begin
    int cyc;
    int cur_lat;
    cyc = 0; cur_lat = 1;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_auto) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
          if (cyc == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat_cfg;
          cyc++;
          if (cur_lat != 0 && cyc == cur_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = ram_read(mem_addr);
            if (mem_we) ram[mem_addr] = mem_wdata;
          end
        end else begin
          cyc = 0;
        end
      end
    end
  end

  // Monitor: scoreboard pops on acks, grant audit, fairness and stability checks.
  initial begin
    bit          prev_req;
    bit          pend_f, pend_d, is_d;
    int          f_skip, d_skip, req_len;
    logic [31:0] grant_addr;
    req_t        e;
    prev_req = 1'b0; f_skip = 0; d_skip = 0; req_len = 0; grant_addr = '0;
    forever begin
      @(negedge clk);
      checkOutput("stall", {31'b0, stall}, {31'b0, (if_req & ~if_ack) | (d_req & ~d_ack)});
      if (if_ack) begin
        if (fq.size() == 0) checkOutput("if_ack_unexpected", 32'h1, 32'h0);
        else begin
          e = fq.pop_front();
          checkOutput("if_rdata", if_rdata, e.rdata);
        end
      end
      if (d_ack) begin
        if (dq.size() == 0) checkOutput("d_ack_unexpected", 32'h1, 32'h0);
        else begin
          e = dq.pop_front();
          checkOutput("d_rdata", d_rdata, e.rdata);
        end
      end
      if (mem_req && !prev_req) begin
        grant_addr = mem_addr;
        req_len    = 1;
        pend_f = (fq.size() > 0);
        pend_d = (dq.size() > 0);
        if (pend_f || pend_d) begin
          is_d = pend_d && !(pend_f && mem_addr[28]);
          grants++;
          if (grants == 1) first_is_d = is_d;
          if (is_d) begin
            checkOutput("grant_d_addr", mem_addr, dq[0].addr);
            checkOutput("grant_d_we", {31'b0, mem_we}, {31'b0, dq[0].we});
            if (dq[0].we) checkOutput("grant_d_wdata", mem_wdata, dq[0].wdata);
            checkOutput("d_wait_bound", {31'b0, d_skip <= 1}, 32'h1);
            d_skip = 0;
            if (pend_f) f_skip++;
          end else begin
            checkOutput("grant_i_addr", mem_addr, fq[0].addr);
            checkOutput("grant_i_we", {31'b0, mem_we}, 32'h0);
            checkOutput("i_wait_bound", {31'b0, f_skip <= 1}, 32'h1);
            f_skip = 0;
            if (pend_d) d_skip++;
          end
        end
      end else if (mem_req) begin
        req_len++;
        checkOutput("mem_addr_stable", mem_addr, grant_addr);
      end
      if (!mem_req && prev_req) last_len = req_len;
      prev_req = mem_req;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int cyc;
    int gap;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_if_ack", {31'b0, if_ack}, 32'h0);
    checkOutput("rst_d_ack", {31'b0, d_ack}, 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    checkOutput("rst_bus_err", {31'b0, bus_err}, 32'h0);
    rst = 1'b0;

    // Random contention: both requesters start together, then random gaps.
    fork
      begin
        int fc;
        for (int i = 0; i < 40; i++) begin
          gap = (i == 0) ? 0 : int'($urandom_range(0, 2));
          repeat (gap) begin @(posedge clk); #1; end
          applyStimulus(1'b0, 1'b0, 32'h1000_0000 | ($urandom & 32'h0000_FFFC), 32'h0, 1'b0, fc);
        end
      end
      begin
        int dc;
        int dgap;
        for (int j = 0; j < 40; j++) begin
          dgap = (j == 0) ? 0 : int'($urandom_range(0, 2));
          repeat (dgap) begin @(posedge clk); #1; end
          applyStimulus(1'b1, 1'($urandom), 32'($urandom_range(0, 7)) << 4, $urandom, 1'b0, dc);
        end
      end
    join
    checkOutput("first_grant_is_d", {31'b0, first_is_d}, 32'h1);
    repeat (3) begin @(posedge clk); #1; end

    // Single fetch with a registered (2-cycle) memory.
    rand_lat = 1'b0;
    lat_cfg  = 2;
    ram[32'h10]     = 32'hA1B2_C3D4;
    ref_mem[32'h10] = 32'hA1B2_C3D4;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, cyc);
    checkOutput("fetch_latency", cyc, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("if_rdata_hold", if_rdata, 32'hA1B2_C3D4);

    // Store then load of the same word.
    lat_cfg = 1;
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h55, 1'b0, cyc);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, cyc);
    checkOutput("load_after_store", d_rdata, 32'h55);

    // Acknowledge lands on the final watchdog cycle.
    lat_cfg = TO;
    applyStimulus(1'b0, 1'b0, 32'h1000_0100, 32'h0, 1'b0, cyc);
    @(negedge clk); #1;
    checkOutput("coincident_req_len", last_len, TO);
    checkOutput("coincident_bus_err", {31'b0, bus_err}, 32'h0);

    // Memory never acknowledges.
    lat_cfg = 0;
    applyStimulus(1'b0, 1'b0, 32'h1000_0200, 32'h0, 1'b1, cyc);
    @(negedge clk); #1;
    checkOutput("wd_req_len", last_len, TO);
    checkOutput("wd_bus_err", {31'b0, bus_err}, 32'h1);
    checkOutput("wd_if_rdata", if_rdata, 32'h0);
    lat_cfg = 1;
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, cyc);
    checkOutput("bus_err_sticky", {31'b0, bus_err}, 32'h1);

    // Reset in the middle of a data access, then a stray acknowledge.
    lat_cfg = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    cyc = 0;
    while (!mem_req && cyc < 10) begin @(posedge clk); #1; cyc++; end
    checkOutput("rm_granted", {31'b0, mem_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_auto = 1'b0;
    mem_ack  = 1'b0;
    @(posedge clk); #1;
    checkOutput("rm_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("rm_mem_addr", mem_addr, 32'h0);
    checkOutput("rm_d_rdata", d_rdata, 32'h0);
    checkOutput("rm_if_rdata", if_rdata, 32'h0);
    checkOutput("rm_bus_err", {31'b0, bus_err}, 32'h0);
    rst = 1'b0;
    d_req = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("rm_no_d_ack", {31'b0, d_ack}, 32'h0);
      checkOutput("rm_no_mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("rm_d_rdata_kept", d_rdata, 32'h0);
      @(posedge clk); #1;
    end
    mem_auto = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
